mem_port_arbiter: RTL and testbench

Arbitrates one shared single-port memory interface between the pipeline's instruction-fetch port and data (load/store) port. Each requester raises a request and holds it until a one-cycle completion pulse; the arbiter grants one requester at a time, drives the memory request/address/data handshake, and returns registered read data. It sits between the pipeline's fetch/memory stages and the memory, and the hazard logic uses `inst_ok`/`data_ok` to release stalls.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared memory port seen by mem_port_arbiter.
// slave = arbiter view; master = requesters plus memory (environment) view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              inst_req;
  logic [AW-1:0]     inst_addr;
  logic [DW-1:0]     inst_rdata;
  logic              inst_ok;

  logic              data_req;
  logic [DW/8-1:0]   data_wen;
  logic [AW-1:0]     data_addr;
  logic [DW-1:0]     data_wdata;
  logic [DW-1:0]     data_rdata;
  logic              data_ok;

  logic              mem_req;
  logic [DW/8-1:0]   mem_wen;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wen, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_rdata, inst_ok,
    output data_rdata, data_ok,
    output mem_req, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wen, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_rdata, inst_ok,
    input  data_rdata, data_ok,
    input  mem_req, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is fixed data-over-instruction priority.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0] state;
  logic       owner;       // 0 = inst, 1 = data
  logic       inst_elig;
  logic       data_elig;
  logic       grant;
  logic       grant_data;

  // A requester seeing its ok this cycle is about to drop; never re-grant it.
  always_comb begin
    inst_elig = bus.inst_req & ~bus.inst_ok;
    data_elig = bus.data_req & ~bus.data_ok;
    grant     = inst_elig | data_elig;
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_data;

  always_comb begin
    grant_data = data_elig & (~inst_elig | prio_data);
  end

  // Point at whichever requester did not win the latest grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_data <= 1'b1;
    end else if (state == S_IDLE && grant) begin
      prio_data <= ~grant_data;
    end
  end
`else
  always_comb begin
    grant_data = data_elig;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      owner          <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_wen    <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.inst_ok    <= 1'b0;
      bus.data_ok    <= 1'b0;
      bus.inst_rdata <= '0;
      bus.data_rdata <= '0;
    end else begin
      bus.inst_ok <= 1'b0;
      bus.data_ok <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            state       <= S_ADDR;
            bus.mem_req <= 1'b1;
            owner       <= grant_data;
            if (grant_data) begin
              bus.mem_addr  <= bus.data_addr;
              bus.mem_wen   <= bus.data_wen;
              bus.mem_wdata <= bus.data_wdata;
            end else begin
              bus.mem_addr  <= bus.inst_addr;
              bus.mem_wen   <= '0;
              bus.mem_wdata <= '0;
            end
          end
        end
        S_ADDR: begin
          if (bus.mem_addr_ok) begin
            state       <= S_DATA;
            bus.mem_req <= 1'b0;
          end
        end
        S_DATA: begin
          // Completion is routed to the recorded owner even if its request has since dropped.
          if (bus.mem_data_ok) begin
            state <= S_IDLE;
            if (owner) begin
              bus.data_rdata <= bus.mem_rdata;
              bus.data_ok    <= 1'b1;
            end else begin
              bus.inst_rdata <= bus.mem_rdata;
              bus.inst_ok    <= 1'b1;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple delay-configurable memory responder.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int   addr_wait = 0;
  int   data_wait = 0;
  logic late_dok  = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h3C080001;
      32'hBFC00004: return 32'h24080002;
      32'h00000100: return 32'hDEADBEEF;
      default:      return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  // Memory model: acks the address after addr_wait cycles, then data after data_wait cycles.
  initial begin
    int          acnt;
    int          dcnt;
    logic        pend;
    logic [31:0] cap_addr;
    acnt = 0; dcnt = 0; pend = 1'b0; cap_addr = '0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
    forever begin
      @(negedge clk);
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = late_dok;
      if (rst) begin
        acnt = 0; dcnt = 0; pend = 1'b0;
      end else if (pend) begin
        if (dcnt == data_wait) begin
          bus.mem_data_ok = 1'b1;
          bus.mem_rdata   = mem_val(cap_addr);
          pend = 1'b0;
          dcnt = 0;
        end else begin
          dcnt++;
        end
      end else if (bus.mem_req) begin
        if (acnt == addr_wait) begin
          bus.mem_addr_ok = 1'b1;
          cap_addr = bus.mem_addr;
          pend = 1'b1;
          acnt = 0;
        end else begin
          acnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_wen   = '0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    checks++; if (bus.mem_req !== 1'b0)          begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_wen !== 4'h0)          begin errors++; $display("FAIL reset_mem_wen: got %h want 0", bus.mem_wen); end
    checks++; if (bus.mem_addr !== 32'h0)        begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0)       begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if (bus.inst_ok !== 1'b0)          begin errors++; $display("FAIL reset_inst_ok: got %b want 0", bus.inst_ok); end
    checks++; if (bus.data_ok !== 1'b0)          begin errors++; $display("FAIL reset_data_ok: got %b want 0", bus.data_ok); end
    checks++; if (bus.inst_rdata !== 32'h0)      begin errors++; $display("FAIL reset_inst_rdata: got %h want 0", bus.inst_rdata); end
    checks++; if (bus.data_rdata !== 32'h0)      begin errors++; $display("FAIL reset_data_rdata: got %h want 0", bus.data_rdata); end
    rst = 1'b0;
    step();
    checks++; if (bus.mem_req !== 1'b0)          begin errors++; $display("FAIL idle_mem_req: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_fetch();
    addr_wait = 0; data_wait = 0;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC00000;
    step();  // cycle 1
    checks++; if (bus.mem_req !== 1'b1)          begin errors++; $display("FAIL fetch_mem_req_c1: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'hBFC00000) begin errors++; $display("FAIL fetch_mem_addr: got %h want bfc00000", bus.mem_addr); end
    checks++; if (bus.mem_wen !== 4'h0)          begin errors++; $display("FAIL fetch_mem_wen: got %h want 0", bus.mem_wen); end
    step();  // cycle 2
    checks++; if (bus.mem_req !== 1'b0)          begin errors++; $display("FAIL fetch_mem_req_c2: got %b want 0", bus.mem_req); end
    checks++; if (bus.inst_ok !== 1'b0)          begin errors++; $display("FAIL fetch_inst_ok_c2: got %b want 0", bus.inst_ok); end
    step();  // cycle 3
    checks++; if (bus.inst_ok !== 1'b1)          begin errors++; $display("FAIL fetch_inst_ok_c3: got %b want 1", bus.inst_ok); end
    checks++; if (bus.inst_rdata !== 32'h3C080001) begin errors++; $display("FAIL fetch_inst_rdata: got %h want 3c080001", bus.inst_rdata); end
    checks++; if (bus.data_ok !== 1'b0)          begin errors++; $display("FAIL fetch_data_ok: got %b want 0", bus.data_ok); end
    bus.inst_req = 1'b0;
    step();  // cycle 4
    checks++; if (bus.inst_ok !== 1'b0)          begin errors++; $display("FAIL fetch_inst_ok_c4: got %b want 0", bus.inst_ok); end
    checks++; if (bus.inst_rdata !== 32'h3C080001) begin errors++; $display("FAIL fetch_rdata_hold: got %h want 3c080001", bus.inst_rdata); end
    checks++; if (bus.mem_req !== 1'b0)          begin errors++; $display("FAIL fetch_no_regrant: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_both();
    addr_wait = 0; data_wait = 0;
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'hBFC00004;
    bus.data_req   = 1'b1;
    bus.data_wen   = 4'h0;
    bus.data_addr  = 32'h00000100;
    bus.data_wdata = 32'hFFFFFFFF;
    step();  // cycle 1
    checks++; if (bus.mem_addr !== 32'h00000100) begin errors++; $display("FAIL both_first_addr: got %h want 00000100", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL both_first_wdata: got %h want ffffffff", bus.mem_wdata); end
    step(); step();  // cycle 3
    checks++; if (bus.data_ok !== 1'b1)          begin errors++; $display("FAIL both_data_ok_c3: got %b want 1", bus.data_ok); end
    checks++; if (bus.data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL both_data_rdata: got %h want deadbeef", bus.data_rdata); end
    checks++; if (bus.inst_ok !== 1'b0)          begin errors++; $display("FAIL both_inst_ok_c3: got %b want 0", bus.inst_ok); end
    bus.data_req = 1'b0;
    step();  // cycle 4
    checks++; if (bus.mem_req !== 1'b1)          begin errors++; $display("FAIL both_second_req: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'hBFC00004) begin errors++; $display("FAIL both_second_addr: got %h want bfc00004", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0)       begin errors++; $display("FAIL both_inst_wdata: got %h want 0", bus.mem_wdata); end
    step(); step();  // cycle 6
    checks++; if (bus.inst_ok !== 1'b1)          begin errors++; $display("FAIL both_inst_ok_c6: got %b want 1", bus.inst_ok); end
    checks++; if (bus.inst_rdata !== 32'h24080002) begin errors++; $display("FAIL both_inst_rdata: got %h want 24080002", bus.inst_rdata); end
    checks++; if (bus.data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL both_data_hold: got %h want deadbeef", bus.data_rdata); end
    bus.inst_req = 1'b0;
    step();
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    addr_wait = 0; data_wait = 0;
    bus.data_req  = 1'b1;
    bus.data_wen  = 4'h0;
    bus.data_addr = 32'h00000100;
    step(); step(); step();  // cycle 3
    checks++; if (bus.data_ok !== 1'b1)          begin errors++; $display("FAIL rr_single_data_ok: got %b want 1", bus.data_ok); end
    bus.data_req = 1'b0;
    step();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC00004;
    bus.data_req  = 1'b1;
    step();  // cycle 1
    checks++; if (bus.mem_addr !== 32'hBFC00004) begin errors++; $display("FAIL rr_inst_first: got %h want bfc00004", bus.mem_addr); end
    step(); step();  // cycle 3
    checks++; if (bus.inst_ok !== 1'b1)          begin errors++; $display("FAIL rr_inst_ok_c3: got %b want 1", bus.inst_ok); end
    bus.inst_req = 1'b0;
    step();  // cycle 4
    checks++; if (bus.mem_addr !== 32'h00000100) begin errors++; $display("FAIL rr_data_second: got %h want 00000100", bus.mem_addr); end
    step(); step();  // cycle 6
    checks++; if (bus.data_ok !== 1'b1)          begin errors++; $display("FAIL rr_data_ok_c6: got %b want 1", bus.data_ok); end
    bus.data_req = 1'b0;
    step();
  endtask
`endif

  task automatic test_store();
    addr_wait = 2; data_wait = 3;
    bus.data_req   = 1'b1;
    bus.data_wen   = 4'b0011;
    bus.data_addr  = 32'h00000200;
    bus.data_wdata = 32'h12341234;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c <= 3) begin
        checks++; if (bus.mem_req !== 1'b1)          begin errors++; $display("FAIL store_mem_req c%0d: got %b want 1", c, bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h00000200) begin errors++; $display("FAIL store_mem_addr c%0d: got %h want 00000200", c, bus.mem_addr); end
        checks++; if (bus.mem_wen !== 4'b0011)       begin errors++; $display("FAIL store_mem_wen c%0d: got %b want 0011", c, bus.mem_wen); end
        checks++; if (bus.mem_wdata !== 32'h12341234) begin errors++; $display("FAIL store_mem_wdata c%0d: got %h want 12341234", c, bus.mem_wdata); end
      end else begin
        checks++; if (bus.mem_req !== 1'b0)          begin errors++; $display("FAIL store_mem_req_low c%0d: got %b want 0", c, bus.mem_req); end
      end
      if (c < 8) begin
        checks++; if (bus.data_ok !== 1'b0)          begin errors++; $display("FAIL store_data_ok_early c%0d: got %b want 0", c, bus.data_ok); end
      end else begin
        checks++; if (bus.data_ok !== 1'b1)          begin errors++; $display("FAIL store_data_ok_c8: got %b want 1", bus.data_ok); end
        checks++; if (bus.data_rdata !== 32'hA5A5A7A5) begin errors++; $display("FAIL store_data_rdata: got %h want a5a5a7a5", bus.data_rdata); end
      end
    end
    bus.data_req = 1'b0;
    bus.data_wen = 4'h0;
    addr_wait = 0; data_wait = 0;
    step();
  endtask

  task automatic test_hold();
    bus.data_req  = 1'b1;
    bus.data_wen  = 4'h0;
    bus.data_addr = 32'h00000300;
    step(); step(); step();  // cycle 3
    checks++; if (bus.data_ok !== 1'b1)          begin errors++; $display("FAIL hold_data_ok_c3: got %b want 1", bus.data_ok); end
    step();  // cycle 4: request was still high at the ok edge
    checks++; if (bus.mem_req !== 1'b0)          begin errors++; $display("FAIL hold_no_regrant: got %b want 0", bus.mem_req); end
    checks++; if (bus.data_ok !== 1'b0)          begin errors++; $display("FAIL hold_data_ok_c4: got %b want 0", bus.data_ok); end
    bus.data_req = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      step();
      checks++; if (bus.mem_req !== 1'b0 || bus.data_ok !== 1'b0) begin errors++; $display("FAIL hold_quiet c%0d: got req=%b ok=%b want 0 0", c, bus.mem_req, bus.data_ok); end
    end
  endtask

  task automatic test_reset_mid();
    addr_wait = 0; data_wait = 10;
    bus.data_req  = 1'b1;
    bus.data_wen  = 4'b1111;
    bus.data_addr = 32'h00000400;
    bus.data_wdata = 32'hCAFEF00D;
    step(); step();  // cycle 2: waiting in DATA
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h00000400) begin errors++; $display("FAIL rstmid_in_data: got req=%b addr=%h want 0 00000400", bus.mem_req, bus.mem_addr); end
    rst = 1'b1;
    bus.data_req = 1'b0;
    step();  // cycle 3
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wen !== 4'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_bus_clear: got addr=%h wen=%h wdata=%h want 0", bus.mem_addr, bus.mem_wen, bus.mem_wdata); end
    checks++; if (bus.data_rdata !== 32'h0 || bus.inst_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata_clear: got d=%h i=%h want 0", bus.data_rdata, bus.inst_rdata); end
    checks++; if (bus.mem_req !== 1'b0 || bus.data_ok !== 1'b0 || bus.inst_ok !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl_clear: got req=%b dok=%b iok=%b want 0", bus.mem_req, bus.data_ok, bus.inst_ok); end
    rst = 1'b0;
    late_dok = 1'b1;
    step();  // cycle 4: late data_ok seen while IDLE
    step();  // cycle 5
    checks++; if (bus.data_ok !== 1'b0 || bus.inst_ok !== 1'b0) begin errors++; $display("FAIL rstmid_late_ok: got dok=%b iok=%b want 0 0", bus.data_ok, bus.inst_ok); end
    checks++; if (bus.data_rdata !== 32'h0)      begin errors++; $display("FAIL rstmid_late_rdata: got %h want 0", bus.data_rdata); end
    late_dok = 1'b0;
    step();
    checks++; if (bus.mem_req !== 1'b0 || bus.data_ok !== 1'b0) begin errors++; $display("FAIL rstmid_after: got req=%b ok=%b want 0 0", bus.mem_req, bus.data_ok); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_both();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_store();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
